band_mac_scheduler: RTL and testbench
=====================================

# band_mac_scheduler

Sequences the single shared 16x16 multiply-accumulate engine across all equalizer bands for each input sample. Per accepted sample it runs every enabled band's 64-tap serial FIR, one tap per cycle, driving the MAC's accumulate/first/latch controls, tap and coefficient addresses, and delay-line shift. It sits between the sample source, the delay pipeline, the coefficient store and the MAC. It tags each saturated result with its band index.

## Interface
- NUM_BANDS, 8, bands sharing the MAC
- NUM_TAPS, 64, taps per band (power of two)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  new input sample offered
- sample_ready  out  1  scheduler idle, sample accepted when valid & ready
- band_en  in  NUM_BANDS  per-band enable mask, sampled on acceptance
- shift_en  out  1  one-cycle pulse: delay pipeline shifts in accepted sample
- mac_en  out  1  to MAC clk_enable (accumulator update)
- mac_first  out  1  to MAC phase_0 (load product, latch previous sum into final register)
- mac_latch  out  1  to MAC phase_63 (load saturated final sum into output register)
- tap_idx  out  log2(NUM_TAPS)  delay-pipeline tap select
- coeff_addr  out  log2(NUM_BANDS)+log2(NUM_TAPS)  {band, tap} coefficient address
- res_valid  out  1  one-cycle pulse: MAC output holds result for res_band
- res_band  out  log2(NUM_BANDS)  band of current result
- busy  out  1  not IDLE

## Operation
- States: IDLE, LOAD, RUN, DRAIN0, DRAIN1.
- IDLE: sample_ready=1. On valid&ready, latch band_en into mask_q. Go to LOAD.
- LOAD:
  - shift_en=1.
  - If mask_q==0, go to IDLE with no results.
  - Otherwise band_q = lowest set bit, tap_q=0, first_band=1. Go to RUN.
- RUN:
  - mac_en=1; tap_idx=tap_q; coeff_addr={band_q,tap_q}. tap_q increments 0..NUM_TAPS-1.
  - mac_first=1 when tap_q==0.
  - mac_latch=1 when tap_q==1 and !first_band. This latches the previous enabled band (prev_band).
  - At tap_q==NUM_TAPS-1: prev_band=band_q, first_band=0.
    - If an enabled band above band_q exists, band_q=next enabled, tap_q=0, stay in RUN.
    - Else go to DRAIN0.
- DRAIN0: mac_first=1, mac_en=0. Last band's sum moves into the final register.
- DRAIN1: mac_latch=1, mac_en=0. Go to IDLE.
- res_valid = mac_latch delayed one cycle. res_band = band latched with mac_latch (prev_band).
- Results emerge in ascending band order, one per enabled band per sample.
- sample_valid while busy: held off, no loss, no error.
- band_en changes after acceptance have no effect until the next sample.
- tap_idx and coeff_addr hold their last value outside RUN.
- mac_en=0 outside RUN.

## Timing
- Reset (async, rst_n low): state=IDLE.
  - All outputs 0 except sample_ready=1.
  - Counters and mask_q cleared.
  - Reset mid-RUN abandons the sample; no res_valid follows.
- Acceptance at cycle 0: LOAD in cycle 1 (shift_en), first RUN tap in cycle 2.
- Per sample with k enabled bands:
  - 1 + 64k + 2 cycles busy.
  - All 8 bands: 515 cycles, then IDLE.
- Latch timing for non-last band b: mac_latch at tap 1 of the following enabled band; res_valid one cycle later.
- Last band: mac_latch in DRAIN1; res_valid in the first IDLE cycle.
- A new sample may be accepted in the same cycle as the final res_valid.
- Simultaneous res_valid and shift_en are impossible (shift_en only in LOAD).

## Structure
- Shared package eq_pkg:
  - NUM_BANDS, NUM_TAPS, derived widths BAND_W/TAP_W.
  - State encoding type (IDLE, LOAD, RUN, DRAIN0, DRAIN1).
- Sub-module eq_band_pick: combinational, from (mask_q, band_q) gives lowest enabled band strictly above band_q plus a found flag. It also computes the lowest set bit for LOAD.
- Everything else (FSM, tap counter, latch/valid pipeline) lives in band_mac_scheduler.

## Test plan
- Sample, band_en=8'hFF:
  - shift_en at cycle 1; mac_first at cycles 2, 66, …, 450, 514.
  - 8 res_valid pulses, bands 0..7 at cycles 68, 132, …, 516.
  - sample_ready back at 516.
- band_en=8'b0000_0101: coeff_addr sweeps band 0 then band 2; 2 results, res_band 0 then 2; busy 131 cycles.
- band_en=0: shift_en pulses once, no mac_en, no res_valid, IDLE two cycles after acceptance.
- Back-to-back samples with sample_valid held high: second accepted at cycle 516; the result count matches the enabled bands for each sample.
- rst_n low at RUN tap 30 of band 3: all outputs 0 immediately, sample_ready=1 after release, no stray res_valid.
- band_en toggled mid-RUN: the sequence follows the mask captured at acceptance.

Source files
------------

// File: rtl/band_mac_scheduler_pkg.sv
// Shared parameters and state encoding for the equalizer MAC scheduler.
// BAND_W/TAP_W are derived widths for band and tap indices; ADDR_W is the
// {band, tap} coefficient address width.
package eq_pkg;
  localparam int NUM_BANDS = 8;
  localparam int NUM_TAPS  = 64;                 // power of two
  localparam int BAND_W    = $clog2(NUM_BANDS);
  localparam int TAP_W     = $clog2(NUM_TAPS);
  localparam int ADDR_W    = BAND_W + TAP_W;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_RUN    = 3'd2;
  localparam state_t ST_DRAIN0 = 3'd3;
  localparam state_t ST_DRAIN1 = 3'd4;
endpackage

// File: rtl/band_mac_scheduler_if.sv
// Bus between the scheduler and its neighbours: sample source handshake,
// delay-line shift, MAC controls, tap/coefficient addressing, result tag.
// master: scheduler side. slave: environment side.
interface band_mac_scheduler_if;
  import eq_pkg::*;
  logic                 sample_valid;
  logic                 sample_ready;
  logic [NUM_BANDS-1:0] band_en;
  logic                 shift_en;
  logic                 mac_en;
  logic                 mac_first;
  logic                 mac_latch;
  logic [TAP_W-1:0]     tap_idx;
  logic [ADDR_W-1:0]    coeff_addr;
  logic                 res_valid;
  logic [BAND_W-1:0]    res_band;
  logic                 busy;

  modport master (
    input  sample_valid, band_en,
    output sample_ready, shift_en, mac_en, mac_first, mac_latch,
           tap_idx, coeff_addr, res_valid, res_band, busy
  );
  modport slave (
    output sample_valid, band_en,
    input  sample_ready, shift_en, mac_en, mac_first, mac_latch,
           tap_idx, coeff_addr, res_valid, res_band, busy
  );
endinterface

// File: rtl/band_mac_scheduler_band_pick.sv
// Combinational band selector.
//   mask       : enabled-band mask captured at acceptance
//   cur        : band currently being run
//   next_band  : lowest enabled band strictly above cur (valid if next_found)
//   next_found : such a band exists
//   low_band   : lowest enabled band overall (0 when mask is empty)
module eq_band_pick
  import eq_pkg::*;
(
  input  logic [NUM_BANDS-1:0] mask,
  input  logic [BAND_W-1:0]    cur,
  output logic [BAND_W-1:0]    next_band,
  output logic                 next_found,
  output logic [BAND_W-1:0]    low_band
);
  // Scan top-down so the last hit written is the lowest one.
  always_comb begin
    next_band  = '0;
    next_found = 1'b0;
    low_band   = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_band = BAND_W'(i);
        if (i > int'(cur)) begin
          next_found = 1'b1;
          next_band  = BAND_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/band_mac_scheduler.sv
// Shared-MAC scheduler: for each accepted sample, runs every enabled band's
// NUM_TAPS-tap FIR one tap per cycle on the single MAC, then drains the last
// sum. Each band's saturated result is tagged with its band on res_band.
//   clk, rst_n : clock, async active-low reset
//   bus        : band_mac_scheduler_if.master (handshake, MAC controls,
//                tap/coeff addresses, result tag, busy)
module band_mac_scheduler
  import eq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  band_mac_scheduler_if.master bus
);
  state_t               state;
  logic [NUM_BANDS-1:0] mask_q;
  logic [BAND_W-1:0]    band_q;
  logic [BAND_W-1:0]    prev_band;
  logic [TAP_W-1:0]     tap_q;
  logic                 first_band;
  logic                 res_valid_q;
  logic [BAND_W-1:0]    res_band_q;

  logic [BAND_W-1:0]    next_band, low_band;
  logic                 next_found;
  logic                 in_run, last_tap, mac_latch;

  eq_band_pick u_pick (
    .mask       (mask_q),
    .cur        (band_q),
    .next_band  (next_band),
    .next_found (next_found),
    .low_band   (low_band)
  );

  assign in_run   = (state == ST_RUN);
  assign last_tap = (tap_q == TAP_W'(NUM_TAPS - 1));
  // Tap 1 of a non-first band latches the previous band's saturated sum;
  // the last band is latched in DRAIN1 after DRAIN0 moves it to final.
  assign mac_latch = (in_run && tap_q == TAP_W'(1) && !first_band) ||
                     (state == ST_DRAIN1);

  assign bus.sample_ready = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.shift_en     = (state == ST_LOAD);
  assign bus.mac_en       = in_run;
  assign bus.mac_first    = (in_run && tap_q == '0) || (state == ST_DRAIN0);
  assign bus.mac_latch    = mac_latch;
  // band_q/tap_q only move on entry to or within RUN, so these hold outside it.
  assign bus.tap_idx      = tap_q;
  assign bus.coeff_addr   = {band_q, tap_q};
  assign bus.res_valid    = res_valid_q;
  assign bus.res_band     = res_band_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      band_q      <= '0;
      prev_band   <= '0;
      tap_q       <= '0;
      first_band  <= 1'b0;
      res_valid_q <= 1'b0;
      res_band_q  <= '0;
    end else begin
      res_valid_q <= mac_latch;
      if (mac_latch) res_band_q <= prev_band;
      case (state)
        ST_IDLE: if (bus.sample_valid) begin
          mask_q <= bus.band_en;
          state  <= ST_LOAD;
        end
        ST_LOAD: if (mask_q == '0) begin
          state <= ST_IDLE;
        end else begin
          band_q     <= low_band;
          tap_q      <= '0;
          first_band <= 1'b1;
          state      <= ST_RUN;
        end
        ST_RUN: if (last_tap) begin
          prev_band  <= band_q;
          first_band <= 1'b0;
          if (next_found) begin
            band_q <= next_band;
            tap_q  <= '0;
          end else begin
            state  <= ST_DRAIN0;     // tap_q stays at the last tap
          end
        end else begin
          tap_q <= tap_q + TAP_W'(1);
        end
        ST_DRAIN0: state <= ST_DRAIN1;
        ST_DRAIN1: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_band_mac_scheduler.sv
// Directed/randomized bench for band_mac_scheduler. Expected outputs for each
// cycle after acceptance come from a timeline model built from the list of
// enabled bands (LOAD, 64 taps per band, DRAIN0, DRAIN1, result tag).
module tb_band_mac_scheduler;
  import eq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;
  logic [ADDR_W-1:0] last_coeff = '0;

  band_mac_scheduler_if bus ();

  band_mac_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 0, 32'(bus.sample_ready), 32'd1);
    chk({tag, "_busy"},  0, 32'(bus.busy),         32'd0);
    chk({tag, "_shift"}, 0, 32'(bus.shift_en),     32'd0);
    chk({tag, "_mac_en"},0, 32'(bus.mac_en),       32'd0);
    chk({tag, "_first"}, 0, 32'(bus.mac_first),    32'd0);
    chk({tag, "_latch"}, 0, 32'(bus.mac_latch),    32'd0);
    chk({tag, "_tap"},   0, 32'(bus.tap_idx),      32'd0);
    chk({tag, "_coeff"}, 0, 32'(bus.coeff_addr),   32'd0);
    chk({tag, "_rv"},    0, 32'(bus.res_valid),    32'd0);
    chk({tag, "_rband"}, 0, 32'(bus.res_band),     32'd0);
  endtask

  // Called at a negedge in an idle cycle (cycle 0). Offers mask m, then checks
  // cycles 1..end; returns at the negedge of the final (idle) cycle, or early
  // after checking cycle abort_t. While busy, band_en is scrambled and
  // sample_valid is held high if hold is set.
  task automatic run_sample(input logic [NUM_BANDS-1:0] m, input bit hold,
                            input int abort_t);
    int b[$];
    int k, T, tend, i, tap, nres;
    bit run, e_first, e_latch, e_rv;
    int e_rb;
    for (int n = 0; n < NUM_BANDS; n++) if (m[n]) b.push_back(n);
    k    = b.size();
    T    = NUM_TAPS * k;
    tend = (k == 0) ? 2 : T + 4;
    nres = 0;
    chk("accept_ready", 0, 32'(bus.sample_ready), 32'd1);
    bus.sample_valid = 1'b1;
    bus.band_en      = m;
    for (int t = 1; t <= tend; t++) begin
      @(negedge clk);
      run = (k > 0) && (t >= 2) && (t <= T + 1);
      i   = run ? (t - 2) / NUM_TAPS : 0;
      tap = run ? (t - 2) % NUM_TAPS : 0;
      e_first = (k > 0) && ((run && tap == 0) || t == T + 2);
      e_latch = (k > 0) && ((run && tap == 1 && i > 0) || t == T + 3);
      e_rv    = (k > 0) && ((run && tap == 2 && i > 0) || t == T + 4);
      e_rb    = (t == T + 4 && k > 0) ? b[k-1] : ((i > 0) ? b[i-1] : 0);
      if (run) last_coeff = {BAND_W'(b[i]), TAP_W'(tap)};
      chk("ready",  t, 32'(bus.sample_ready), 32'(t == tend));
      chk("busy",   t, 32'(bus.busy),         32'(t != tend));
      chk("shift",  t, 32'(bus.shift_en),     32'(t == 1));
      chk("mac_en", t, 32'(bus.mac_en),       32'(run));
      chk("first",  t, 32'(bus.mac_first),    32'(e_first));
      chk("latch",  t, 32'(bus.mac_latch),    32'(e_latch));
      chk("res_valid", t, 32'(bus.res_valid), 32'(e_rv));
      if (e_rv) begin
        nres++;
        chk("res_band", t, 32'(bus.res_band), 32'(e_rb));
      end
      chk("coeff",  t, 32'(bus.coeff_addr),   32'(last_coeff));
      chk("tap",    t, 32'(bus.tap_idx),      32'(last_coeff[TAP_W-1:0]));
      if (t == abort_t) return;
      bus.band_en      = NUM_BANDS'($urandom);
      bus.sample_valid = (t == tend) ? 1'b0 : hold;
    end
    chk("result_count", 0, 32'(nres), 32'(k));
  endtask

  initial begin
    logic [NUM_BANDS-1:0] m;
    bus.sample_valid = 1'b0;
    bus.band_en      = '0;
    #1;
    chk_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sample(8'hFF, 1'b0, -1);              // all bands: 515 busy cycles
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    run_sample(8'b0000_0101, 1'b0, -1);       // bands 0 and 2
    run_sample(8'h00, 1'b0, -1);              // empty mask: shift only
    // Back-to-back with valid held high, including single-band edges.
    run_sample(8'h80, 1'b1, -1);
    run_sample(8'h01, 1'b1, -1);
    for (int r = 0; r < 3; r++) begin
      m = NUM_BANDS'($urandom);
      run_sample(m, 1'b1, -1);
    end
    run_sample(8'hFF, 1'b1, -1);

    // Reset during band 3, tap 30 (band 3 is the third enabled band).
    run_sample(8'b0000_1011, 1'b0, 2 + 2 * NUM_TAPS + 30);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    last_coeff = '0;
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NUM_TAPS + 8; c++) begin
      @(negedge clk);
      chk("post_rst_rv",    c, 32'(bus.res_valid),    32'd0);
      chk("post_rst_ready", c, 32'(bus.sample_ready), 32'd1);
    end
    m = NUM_BANDS'($urandom) | 8'h40;
    run_sample(m, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
